// File: rtl/inst_fetch_queue.sv
// Circular instruction buffer between IF and ID: holds {pc, pcp4, inst} per entry,
// presents the head combinationally and tags delay-slot heads across dequeues.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [AW-1:0]            if_pc,
  input  logic [AW-1:0]            if_pcp4,
  input  logic [DW-1:0]            if_inst,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [AW-1:0]            id_pc,
  output logic [AW-1:0]            id_pcp4,
  output logic [DW-1:0]            id_inst,
  input  logic                     id_isbranch,
  output logic                     id_inslot,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [AW-1:0] pc_mem   [DEPTH];
  logic [AW-1:0] pcp4_mem [DEPTH];
  logic [DW-1:0] inst_mem [DEPTH];

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          slot_q, slot_d;

  logic full, empty, push, pop;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  // Full rejects pushes regardless of a same-cycle pop, so if_ready never sees id_ready.
  assign if_ready = !full && !rst;
  assign id_valid = !empty;
  assign push     = if_valid && if_ready;
  assign pop      = id_valid && id_ready;

  assign id_pc     = empty ? '0 : pc_mem[rp_q];
  assign id_pcp4   = empty ? '0 : pcp4_mem[rp_q];
  assign id_inst   = empty ? '0 : inst_mem[rp_q];
  assign id_inslot = slot_q && id_valid;
  assign count     = count_q;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    slot_d  = slot_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      slot_d  = 1'b0;
    end else begin
      if (push) wp_d = wp_q + PTR_ONE;
      if (pop) begin
        rp_d   = rp_q + PTR_ONE;
        slot_d = id_isbranch;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      slot_q  <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      slot_q  <= slot_d;
    end
  end

  // Entry storage carries no reset; empty-forcing on the head hides stale contents.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && !flush && (wp_q == PW'(gi))) begin
        pc_mem[gi]   <= if_pc;
        pcp4_mem[gi] <= if_pcp4;
        inst_mem[gi] <= if_inst;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, flush, if_valid, id_ready, id_isbranch;
  logic [AW-1:0] if_pc, if_pcp4;
  logic [DW-1:0] if_inst;
  logic          if_ready, id_valid, id_inslot;
  logic [AW-1:0] id_pc, id_pcp4;
  logic [DW-1:0] id_inst;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] pcp4;
    logic [DW-1:0] inst;
  } entry_t;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_pcp4(if_pcp4), .if_inst(if_inst),
    .id_ready(id_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_pcp4(id_pcp4), .id_inst(id_inst),
    .id_isbranch(id_isbranch), .id_inslot(id_inslot), .count(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; if_valid = 0; id_ready = 0; id_isbranch = 0;
  endtask

  task automatic set_push(input logic [AW-1:0] pc);
    if_valid = 1; if_pc = pc; if_pcp4 = pc + 4; if_inst = pc ^ 32'h1357_0000;
  endtask

  task automatic test_reset();
    rst = 1; idle(); if_pc = 0; if_pcp4 = 0; if_inst = 0;
    tick(); tick();
    checks++;
    if (id_valid !== 1'b0 || count !== 3'd0 || if_ready !== 1'b0 || id_pc !== '0 ||
        id_pcp4 !== '0 || id_inst !== '0 || id_inslot !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%0b count=%0d if_ready=%0b pc=%h inslot=%0b required 0,0,0,0,0",
               id_valid, count, if_ready, id_pc, id_inslot);
    end
    rst = 0; #1;
    checks++;
    if (if_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release if_ready=%0b required 1", if_ready);
    end
    $display("reset: done");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      set_push(32'h100 + 4 * i);
      tick();
      checks++;
      if (id_pc !== 32'h100 || count !== 3'(i + 1)) begin
        errors++;
        $display("FAIL fill_%0d id_pc=%h count=%0d required 100,%0d", i, id_pc, count, i + 1);
      end
    end
    checks++;
    if (if_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full if_ready=%0b required 0", if_ready);
    end
    set_push(32'h110);
    tick();
    checks++;
    if (count !== 3'd4 || id_pc !== 32'h100 || id_pcp4 !== 32'h104) begin
      errors++;
      $display("FAIL fill_reject count=%0d id_pc=%h id_pcp4=%h required 4,100,104", count, id_pc, id_pcp4);
    end
    idle();
    $display("fill: count=%0d head=%h", count, id_pc);
  endtask

  task automatic test_full_pushpop();
    set_push(32'h110); id_ready = 1;
    tick();
    idle();
    checks++;
    if (count !== 3'd3 || id_pc !== 32'h104) begin
      errors++; $display("FAIL full_pushpop count=%0d id_pc=%h required 3,104", count, id_pc);
    end
    id_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (id_pc !== 32'h104 + 4 * i || id_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain_%0d id_pc=%h valid=%0b required %h,1", i, id_pc, id_valid, 32'h104 + 4 * i);
      end
      tick();
    end
    idle();
    checks++;
    if (id_valid !== 1'b0 || count !== 3'd0 || id_pc !== '0) begin
      errors++; $display("FAIL drain_empty valid=%0b count=%0d pc=%h required 0,0,0", id_valid, count, id_pc);
    end
    $display("full_pushpop: drained, count=%0d", count);
  endtask

  task automatic test_delay_slot();
    set_push(32'h200); tick();
    set_push(32'h204); tick();
    idle();
    checks++;
    if (id_pc !== 32'h200 || id_inslot !== 1'b0) begin
      errors++; $display("FAIL slot_head id_pc=%h inslot=%0b required 200,0", id_pc, id_inslot);
    end
    id_ready = 1; id_isbranch = 1; tick();
    checks++;
    if (id_pc !== 32'h204 || id_inslot !== 1'b1) begin
      errors++; $display("FAIL slot_tag id_pc=%h inslot=%0b required 204,1", id_pc, id_inslot);
    end
    id_isbranch = 0; tick();
    idle();
    checks++;
    if (id_valid !== 1'b0 || id_inslot !== 1'b0) begin
      errors++; $display("FAIL slot_clear valid=%0b inslot=%0b required 0,0", id_valid, id_inslot);
    end
    $display("delay_slot: done");
  endtask

  task automatic test_late_slot();
    set_push(32'h300); tick();
    idle(); id_ready = 1; id_isbranch = 1; tick();
    idle();
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (id_valid !== 1'b0 || id_inslot !== 1'b0) begin
      errors++; $display("FAIL late_empty valid=%0b inslot=%0b required 0,0", id_valid, id_inslot);
    end
    set_push(32'h304); tick();
    idle();
    checks++;
    if (id_valid !== 1'b1 || id_inslot !== 1'b1 || id_pc !== 32'h304) begin
      errors++;
      $display("FAIL late_slot valid=%0b inslot=%0b pc=%h required 1,1,304", id_valid, id_inslot, id_pc);
    end
    id_ready = 1; tick(); idle();
    $display("late_slot: done");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      set_push(32'h400 + 4 * i); tick();
    end
    idle(); id_ready = 1; id_isbranch = 1; tick();
    idle();
    checks++;
    if (count !== 3'd3 || id_inslot !== 1'b1) begin
      errors++; $display("FAIL flush_setup count=%0d inslot=%0b required 3,1", count, id_inslot);
    end
    flush = 1; set_push(32'h500); id_ready = 1; tick();
    idle();
    checks++;
    if (count !== 3'd0 || id_valid !== 1'b0 || id_inst !== '0 || id_inslot !== 1'b0 || if_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush count=%0d valid=%0b inst=%h inslot=%0b if_ready=%0b required 0,0,0,0,1",
               count, id_valid, id_inst, id_inslot, if_ready);
    end
    set_push(32'hBFC0_0380); tick();
    idle();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'hBFC0_0380 || id_inslot !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL flush_push valid=%0b pc=%h inslot=%0b count=%0d required 1,bfc00380,0,1",
               id_valid, id_pc, id_inslot, count);
    end
    flush = 1; tick(); idle();
    $display("flush: done");
  endtask

  task automatic test_random();
    entry_t        q[$];
    entry_t        head;
    logic          slot = 0;
    logic [AW-1:0] next_pc = 32'h1000;
    logic          do_push, do_pop;
    int            bad = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if_valid    = ($urandom_range(0, 9) < 7);
      id_ready    = ($urandom_range(0, 9) < 6);
      id_isbranch = $urandom_range(0, 1);
      flush       = ($urandom_range(0, 99) < 3);
      if_pc = next_pc; if_pcp4 = next_pc + 4; if_inst = $urandom;
      #1;
      head = (q.size() != 0) ? q[0] : '0;
      checks++;
      if (id_valid !== (q.size() != 0) || count !== 3'(q.size()) || if_ready !== (q.size() < DEPTH) ||
          id_pc !== head.pc || id_pcp4 !== head.pcp4 || id_inst !== head.inst ||
          id_inslot !== (slot && q.size() != 0) || count > 3'd4) begin
        errors++; bad++;
        $display("FAIL random_%0d valid=%0b count=%0d if_ready=%0b pc=%h inst=%h inslot=%0b required %0b,%0d,%0b,%h,%h,%0b",
                 cyc, id_valid, count, if_ready, id_pc, id_inst, id_inslot,
                 q.size() != 0, q.size(), q.size() < DEPTH, head.pc, head.inst, slot && q.size() != 0);
      end
      do_push = if_valid && (q.size() < DEPTH);
      do_pop  = id_ready && (q.size() != 0);
      if (flush) begin
        q.delete(); slot = 0;
      end else begin
        if (do_pop) begin
          slot = id_isbranch;
          void'(q.pop_front());
        end
        if (do_push) q.push_back('{pc: if_pc, pcp4: if_pcp4, inst: if_inst});
      end
      if (do_push && !flush) next_pc = next_pc + 4;
      @(posedge clk); #1;
    end
    idle();
    $display("random: 1000 cycles, %0d bad", bad);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pushpop();
    test_delay_slot();
    test_late_slot();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised instruction buffer between the IF and ID stages, replacing the single-entry IF/ID pipeline register. It holds up to DEPTH fetched instructions with their PC and PC+4, so fetch can run ahead while decode is stalled. Delivery to ID uses a valid/ready handshake. The queue also tracks branch-delay-slot membership across dequeues and supports a single-cycle flush. It sits between the fetch unit/I-cache port and the decode stage.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- AW, 32, address width of pc/pcp4
- DW, 32, instruction width

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all entries and slot state (exception/eret/redirect)
- if_valid  in  1  fetch presents an instruction this cycle
- if_ready  out  1  queue accepts an entry; equals !full; 0 while rst=1
- if_pc  in  AW  PC of fetched instruction
- if_pcp4  in  AW  PC+4 of fetched instruction
- if_inst  in  DW  fetched instruction word
- id_ready  in  1  ID consumes head this cycle (= !ID stall)
- id_valid  out  1  head entry present (!empty)
- id_pc  out  AW  head PC; 0 when empty
- id_pcp4  out  AW  head PC+4; 0 when empty
- id_inst  out  DW  head instruction; 0 (NOP) when empty
- id_isbranch  in  1  ID decodes current head as branch/jump (combinational from id_inst)
- id_inslot  out  1  current head is the delay slot of the previously consumed instruction
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH-entry circular buffer of {pc, pcp4, inst}. Write pointer wp and read pointer rp are $clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately.
- push = if_valid & if_ready. pop = id_valid & id_ready.
- Push writes entry[wp] and advances wp. Pop advances rp.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- full = (count == DEPTH). empty = (count == 0).
- Full queue: if_ready=0 and pushes are rejected, even if a pop occurs the same cycle. There is no bypass for a full queue.
- Empty queue with if_valid=1: the entry is written and becomes visible at id_* the next cycle. There is no combinational IF→ID bypass.
- Head outputs are a combinational read of entry[rp], forced to zero when empty.
- Slot tracking: register slot_pending.
  - On pop, slot_pending ← id_isbranch.
  - id_inslot = slot_pending & id_valid.
  - slot_pending persists across empty cycles until the next pop, so a delay slot arriving late is still tagged.
- flush: on the next edge wp=rp=0, count=0, slot_pending=0. A push or pop in the same cycle is ignored. flush has priority over everything except rst.
- rst: same clearing as flush. Outputs go to reset values at the first edge with rst=1 and stay there while rst is held.

## Timing
- Reset values: id_valid=0, id_pc=0, id_pcp4=0, id_inst=0, id_inslot=0, count=0, if_ready=0 during rst and 1 on the first cycle after rst deasserts.
- Latency: an entry pushed at edge N is presented at id_* after edge N, i.e. 1 cycle from push to head.
- Throughput: 1 push and 1 pop per cycle sustained when 0<count<DEPTH.
- if_ready and id_valid depend only on registered state. There is no combinational path from id_ready to if_ready.
- id_inslot depends on registered state only. id_isbranch is sampled only at a pop edge.
- Stall (id_ready=0): head and id_inslot hold. Fetch fills until full.
- Flush mid-fill or mid-drain: the queue is empty after one edge and accepts a push on the following cycle.
- Pointer wrap: consecutive push/pop across entry DEPTH−1→0 preserves order.

## Test plan
- Reset/fill: hold rst 2 cycles, then push PCs 0x100,0x104,0x108,0x10C with id_ready=0. Required: count reaches 4 and if_ready=0 after the 4th push. A 5th push at 0x110 is ignored. id_pc=0x100 throughout.
- Full with simultaneous push/pop: with the queue full, assert if_valid (0x110) and id_ready together. Required: the pop occurs, the push is rejected, count=3, and next id_pc=0x104.
- Delay slot: enqueue a beq at 0x200 and an add at 0x204. Pop the beq with id_isbranch=1. Required: head 0x204 shows id_inslot=1. After that pop with id_isbranch=0, id_inslot=0.
- Late slot: pop a branch at 0x300 while the queue is empty behind it. Hold empty 3 cycles, then push 0x304. Required: 0x304 shows id_valid=1 and id_inslot=1.
- Flush: with count=3, slot_pending=1, and if_valid=1 and id_ready=1 in the same cycle, assert flush. Required next cycle: count=0, id_valid=0, id_inst=0, id_inslot=0. The next push at 0xBFC00380 appears with id_inslot=0.
- Wrap stress: run 1000 random push/pop cycles with DEPTH=4 and occasional flush against a reference model. Required: in-order delivery, no loss or duplication, and count always within 0..4.
